display_arbiter: RTL and testbench
==================================

// Module: display_arbiter
// PURPOSE
//   Shares the two-digit segment display (D_0/D_1 inputs of Segment_display) between three requesters.
//   Sources: background status (always present), recording/playback counter (level request), timed alert overlay (pulse request).
//   Fixed priority: overlay > counter > background.
//   Overlay holds for a programmable time, optionally blinks, then returns to the next active source.
// PARAMETERS
//   HOLD_CYCLES  100_000_000  overlay display time in clock cycles (>=1; 1 s at 100 MHz)
//   BLINK_HALF   25_000_000   overlay blink half-period in clock cycles (>=1)
// PORTS
//   clock      in   1  system clock, 100 MHz
//   reset      in   1  synchronous, active-high reset
//   bg_d0      in   4  background digit 0
//   bg_d1      in   4  background digit 1
//   cnt_req    in   1  counter source wants display (level)
//   cnt_d0     in   4  counter digit 0
//   cnt_d1     in   4  counter digit 1
//   ovl_req    in   1  overlay trigger (sampled every edge; pulse or level)
//   ovl_d0     in   4  overlay digit 0, captured on trigger
//   ovl_d1     in   4  overlay digit 1, captured on trigger
//   ovl_blink  in   1  overlay blink enable, captured on trigger
//   D_0        out  4  digit 0 to Segment_display
//   D_1        out  4  digit 1 to Segment_display
//   blank      out  1  1 = display must be blanked
//   owner      out  2  current owner: 0=bg, 1=cnt, 2=ovl
//   ovl_busy   out  1  overlay active
//   ovl_done   out  1  one-cycle pulse when overlay expires
// BEHAVIOUR
//   Reset values: state BG, D_0=D_1=0, blank=0, owner=0, ovl_busy=0, ovl_done=0; hold and blink counters = 0.
//   Reset mid-overlay: returns to the reset values on the next edge; no ovl_done pulse.
//   All outputs are registered. State and outputs update on the same edge.
//   FSM states:
//     BG  -> OVL if ovl_req; else CNT if cnt_req; else stay.
//     CNT -> OVL if ovl_req; else BG if !cnt_req; else stay.
//     OVL -> exit only when the hold counter is 0 at an edge.
//            Exit goes to CNT if cnt_req, else BG.
//   BG/CNT: D_0/D_1 track the selected source live with 1-cycle latency. blank=0.
//   Overlay entry, on the edge where ovl_req=1:
//     - capture ovl_d0/ovl_d1/ovl_blink;
//     - set owner=2, ovl_busy=1;
//     - load hold counter with HOLD_CYCLES-1;
//     - clear blink counter and set blank=0.
//   Overlay timing:
//     - Each further OVL edge decrements the hold counter.
//     - Overlay is visible for exactly HOLD_CYCLES cycles.
//   Overlay exit edge:
//     - ovl_done=1 for that one cycle; ovl_busy=0;
//     - owner and D_0/D_1 take the new source's value on the same edge.
//   Retrigger: ovl_req=1 while in OVL, including on the expiry edge.
//     - Recaptures data and blink; reloads HOLD_CYCLES-1; clears blink counter and sets blank=0.
//     - Retrigger on the expiry edge takes precedence: no exit, no ovl_done.
//   Blink (captured blink=1):
//     - Blink counter counts 0..BLINK_HALF-1 and wraps.
//     - blank toggles on each wrap.
//     - The first BLINK_HALF cycles are unblanked.
//   Blink (captured blink=0): blank stays 0.
//   blank is forced to 0 outside OVL.
//   cnt_req toggling during OVL has no effect until exit; it is sampled at the exit edge.
//   Counter widths: $clog2 of the parameter, minimum 1 bit; no overflow is possible.
// TESTING (HOLD_CYCLES=8, BLINK_HALF=2)
//   1. Reset high 3 cycles, bg=3/7:
//      -> all outputs 0 during reset;
//      -> first edge after release: D_0=3, D_1=7, owner=0.
//   2. cnt_req=1 with 1/2, then cnt_req=0:
//      -> owner=1 and D=1/2 one edge later;
//      -> back to 3/7, owner=0 one edge after the drop.
//   3. cnt_req=1, 1-cycle ovl_req with 9/9:
//      -> owner=2 and D=9/9 for exactly 8 cycles;
//      -> ovl_done high 1 cycle on the 8th edge;
//      -> owner=1, D=1/2 at that edge.
//   4. ovl_req with ovl_blink=1:
//      -> blank over the 8 overlay cycles = 0,0,1,1,0,0,1,1;
//      -> blank=0 after exit.
//   5. Retrigger with A/B at the 5th overlay cycle:
//      -> D=A/B;
//      -> overlay lasts 8 more cycles;
//      -> exactly one ovl_done in total.
//      Also retrigger exactly on the expiry edge -> no ovl_done.
//   6. reset=1 at the 4th overlay cycle:
//      -> next edge owner=0, ovl_busy=0, D=0/0, blank=0;
//      -> ovl_done never pulses.

Source files
------------

// File: rtl/display_arbiter_if.sv
// Signal bundle between the display arbiter and its three sources and the segment display.
// The arbiter uses the slave modport. The sources and the display side use the master modport.
interface display_arbiter_if;
  logic [3:0] bg_d0;
  logic [3:0] bg_d1;
  logic       cnt_req;
  logic [3:0] cnt_d0;
  logic [3:0] cnt_d1;
  logic       ovl_req;
  logic [3:0] ovl_d0;
  logic [3:0] ovl_d1;
  logic       ovl_blink;
  logic [3:0] D_0;
  logic [3:0] D_1;
  logic       blank;
  logic [1:0] owner;
  logic       ovl_busy;
  logic       ovl_done;

  modport master (
    output bg_d0, bg_d1, cnt_req, cnt_d0, cnt_d1, ovl_req, ovl_d0, ovl_d1, ovl_blink,
    input  D_0, D_1, blank, owner, ovl_busy, ovl_done
  );

  modport slave (
    input  bg_d0, bg_d1, cnt_req, cnt_d0, cnt_d1, ovl_req, ovl_d0, ovl_d1, ovl_blink,
    output D_0, D_1, blank, owner, ovl_busy, ovl_done
  );
endinterface

// File: rtl/display_arbiter.sv
// Fixed-priority owner of the two-digit display: a timed overlay beats the counter, and the
// counter beats the background. Every output is registered.
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned BLINK_HALF  = 25_000_000
) (
  input logic               clock,
  input logic               reset,
  display_arbiter_if.slave  bus
);

  localparam int unsigned HoldW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned BlinkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {StBg, StCnt, StOvl} state_e;

  state_e              state_q, state_d;
  logic [3:0]          d0_q, d0_d, d1_q, d1_d;
  logic [1:0]          owner_q, owner_d;
  logic                blank_q, blank_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                blink_en_q, blink_en_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;

  always_comb begin
    state_d     = state_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    owner_d     = owner_q;
    blank_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    blink_en_d  = blink_en_q;
    hold_d      = hold_q;
    blink_cnt_d = blink_cnt_q;

    // A trigger always wins, even on the expiry edge of a running overlay.
    if (bus.ovl_req) begin
      state_d     = StOvl;
      d0_d        = bus.ovl_d0;
      d1_d        = bus.ovl_d1;
      blink_en_d  = bus.ovl_blink;
      owner_d     = 2'd2;
      busy_d      = 1'b1;
      hold_d      = HoldW'(HOLD_CYCLES - 1);
      blink_cnt_d = '0;
    end else if (state_q == StOvl && hold_q != '0) begin
      busy_d  = 1'b1;
      hold_d  = hold_q - 1'b1;
      blank_d = blank_q;
      if (blink_cnt_q == BlinkW'(BLINK_HALF - 1)) begin
        blink_cnt_d = '0;
        blank_d     = blink_en_q & ~blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else begin
      // Plain BG/CNT selection. This also serves as the overlay exit edge.
      done_d = (state_q == StOvl);
      if (bus.cnt_req) begin
        state_d = StCnt;
        d0_d    = bus.cnt_d0;
        d1_d    = bus.cnt_d1;
        owner_d = 2'd1;
      end else begin
        state_d = StBg;
        d0_d    = bus.bg_d0;
        d1_d    = bus.bg_d1;
        owner_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StBg;
      d0_q        <= '0;
      d1_q        <= '0;
      owner_q     <= '0;
      blank_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      blink_en_q  <= 1'b0;
      hold_q      <= '0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      owner_q     <= owner_d;
      blank_q     <= blank_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      blink_en_q  <= blink_en_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign bus.D_0      = d0_q;
  assign bus.D_1      = d1_q;
  assign bus.blank    = blank_q;
  assign bus.owner    = owner_q;
  assign bus.ovl_busy = busy_q;
  assign bus.ovl_done = done_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed checks of display_arbiter with HOLD_CYCLES=8 and BLINK_HALF=2.
// Outputs are sampled 1 time unit after each rising edge.
module tb_display_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  display_arbiter_if dif ();

  display_arbiter #(
    .HOLD_CYCLES(8),
    .BLINK_HALF (2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (dif.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic trigger(input logic [3:0] a, input logic [3:0] b, input logic blink);
    dif.ovl_req   = 1'b1;
    dif.ovl_d0    = a;
    dif.ovl_d1    = b;
    dif.ovl_blink = blink;
  endtask

  task automatic test_reset();
    dif.bg_d0 = 4'd3; dif.bg_d1 = 4'd7;
    dif.cnt_req = 1'b0; dif.cnt_d0 = 4'd0; dif.cnt_d1 = 4'd0;
    dif.ovl_req = 1'b0; dif.ovl_d0 = 4'd0; dif.ovl_d1 = 4'd0; dif.ovl_blink = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({dif.D_0, dif.D_1, dif.blank, dif.owner, dif.ovl_busy, dif.ovl_done} !== 15'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: got D=%h/%h blank=%b owner=%0d busy=%b done=%b, want all 0",
                 i, dif.D_0, dif.D_1, dif.blank, dif.owner, dif.ovl_busy, dif.ovl_done);
      end
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if ({dif.D_0, dif.D_1, dif.owner} !== {4'd3, 4'd7, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_release: got D=%h/%h owner=%0d, want 3/7 owner 0",
               dif.D_0, dif.D_1, dif.owner);
    end
  endtask

  task automatic test_counter();
    dif.cnt_req = 1'b1; dif.cnt_d0 = 4'd1; dif.cnt_d1 = 4'd2;
    tick();
    n_checks++;
    if ({dif.D_0, dif.D_1, dif.owner} !== {4'd1, 4'd2, 2'd1}) begin
      n_fail++;
      $display("FAIL cnt_take: got D=%h/%h owner=%0d, want 1/2 owner 1", dif.D_0, dif.D_1, dif.owner);
    end
    dif.cnt_req = 1'b0;
    tick();
    n_checks++;
    if ({dif.D_0, dif.D_1, dif.owner} !== {4'd3, 4'd7, 2'd0}) begin
      n_fail++;
      $display("FAIL cnt_drop: got D=%h/%h owner=%0d, want 3/7 owner 0", dif.D_0, dif.D_1, dif.owner);
    end
  endtask

  task automatic test_overlay();
    dif.cnt_req = 1'b1;
    tick();
    trigger(4'd9, 4'd9, 1'b0);
    tick();
    dif.ovl_req = 1'b0;
    n_checks++;
    if ({dif.D_0, dif.D_1, dif.owner, dif.ovl_busy, dif.ovl_done} !== {4'd9, 4'd9, 2'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ovl_entry: got D=%h/%h owner=%0d busy=%b done=%b, want 9/9 owner 2 busy 1 done 0",
               dif.D_0, dif.D_1, dif.owner, dif.ovl_busy, dif.ovl_done);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      n_checks++;
      if ({dif.owner, dif.ovl_busy, dif.ovl_done, dif.blank} !== {2'd2, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL ovl_hold cyc%0d: got owner=%0d busy=%b done=%b blank=%b, want 2/1/0/0",
                 i, dif.owner, dif.ovl_busy, dif.ovl_done, dif.blank);
      end
    end
    tick();
    n_checks++;
    if ({dif.D_0, dif.D_1, dif.owner, dif.ovl_busy, dif.ovl_done} !== {4'd1, 4'd2, 2'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovl_exit: got D=%h/%h owner=%0d busy=%b done=%b, want 1/2 owner 1 busy 0 done 1",
               dif.D_0, dif.D_1, dif.owner, dif.ovl_busy, dif.ovl_done);
    end
    tick();
    n_checks++;
    if (dif.ovl_done !== 1'b0) begin
      n_fail++;
      $display("FAIL ovl_done_width: got %b, want 0", dif.ovl_done);
    end
    dif.cnt_req = 1'b0;
    tick();
  endtask

  task automatic test_blink();
    logic [7:0] pat;
    pat = 8'b1100_1100;  // bit i = blank after overlay cycle i
    trigger(4'd5, 4'd6, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      dif.ovl_req = 1'b0;
      n_checks++;
      if (dif.blank !== pat[i]) begin
        n_fail++;
        $display("FAIL blink cyc%0d: got blank=%b, want %b", i, dif.blank, pat[i]);
      end
    end
    tick();
    n_checks++;
    if ({dif.blank, dif.owner, dif.ovl_done} !== {1'b0, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL blink_exit: got blank=%b owner=%0d done=%b, want 0/0/1",
               dif.blank, dif.owner, dif.ovl_done);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    trigger(4'd9, 4'd9, 1'b0);
    tick();
    dif.ovl_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      dones += int'(dif.ovl_done);
    end
    trigger(4'hA, 4'hB, 1'b0);
    tick();
    dif.ovl_req = 1'b0;
    n_checks++;
    if ({dif.D_0, dif.D_1, dif.owner} !== {4'hA, 4'hB, 2'd2}) begin
      n_fail++;
      $display("FAIL retrig_data: got D=%h/%h owner=%0d, want A/B owner 2", dif.D_0, dif.D_1, dif.owner);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      dones += int'(dif.ovl_done);
      n_checks++;
      if (dif.owner !== 2'd2) begin
        n_fail++;
        $display("FAIL retrig_hold cyc%0d: got owner=%0d, want 2", i, dif.owner);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      dones += int'(dif.ovl_done);
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL retrig_done_count: got %0d pulses, want 1", dones);
    end

    // Retrigger landing exactly on the expiry edge.
    trigger(4'd4, 4'd4, 1'b0);
    tick();
    dif.ovl_req = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    trigger(4'hC, 4'hD, 1'b0);
    tick();
    dif.ovl_req = 1'b0;
    n_checks++;
    if ({dif.D_0, dif.D_1, dif.owner, dif.ovl_busy, dif.ovl_done} !== {4'hC, 4'hD, 2'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL expiry_retrig: got D=%h/%h owner=%0d busy=%b done=%b, want C/D owner 2 busy 1 done 0",
               dif.D_0, dif.D_1, dif.owner, dif.ovl_busy, dif.ovl_done);
    end
    for (int i = 1; i < 8; i++) tick();
    tick();
    n_checks++;
    if ({dif.ovl_done, dif.owner} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL expiry_retrig_exit: got done=%b owner=%0d, want 1/0", dif.ovl_done, dif.owner);
    end
    tick();
  endtask

  task automatic test_reset_mid_overlay();
    trigger(4'd8, 4'd8, 1'b1);
    tick();
    dif.ovl_req = 1'b0;
    for (int i = 1; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({dif.D_0, dif.D_1, dif.blank, dif.owner, dif.ovl_busy, dif.ovl_done} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got D=%h/%h blank=%b owner=%0d busy=%b done=%b, want all 0",
               dif.D_0, dif.D_1, dif.blank, dif.owner, dif.ovl_busy, dif.ovl_done);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (dif.ovl_done !== 1'b0 || dif.owner !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_mid_after cyc%0d: got done=%b owner=%0d, want 0/0",
                 i, dif.ovl_done, dif.owner);
      end
    end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_overlay();
    test_blink();
    test_back_to_back();
    test_reset_mid_overlay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
